// File: rtl/rhythm_seq.sv
// rhythm_seq -- step sequencer driven by an upstream tempo tick.
//
// Plays one pattern step per rising edge of tick_in. Each step holds a
// hit bit and an optional accent bit. A hit raises beat for GATE_LEN clk
// cycles; a new tick retriggers the gate. bar_start pulses when step 0 plays.
//
// Optional feature macro: RHYTHM_SEQ_ACCENT_EN
//   defined   -> per-step accent bit is stored and driven on accent
//   undefined -> accent bit is not stored, accent output tied low
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   tick_in    in   tempo clock level (clk-synchronous)
//   enable     in   run request; low stops and rewinds
//   pat_we     in   pattern write strobe
//   pat_addr   in   [3:0] step index to write (>= STEPS ignored)
//   pat_data   in   [1:0] bit0 = hit, bit1 = accent
//   step       out  [3:0] index of the step most recently played
//   beat       out  gate pulse for a hit step
//   accent     out  accent flag, valid while beat is high
//   bar_start  out  one-cycle pulse when step 0 plays
module rhythm_seq #(
  parameter int STEPS    = 16,
  parameter int GATE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic [1:0] pat_data,
  output logic [3:0] step,
  output logic       beat,
  output logic       accent,
  output logic       bar_start
);

  localparam logic [3:0] LAST_STEP   = 4'(STEPS - 1);
  // The play cycle itself counts as the first gate cycle, so the counter
  // holds the number of cycles still to go after it.
  localparam logic [7:0] GATE_RELOAD = 8'(GATE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        tick_q;
  logic        tick_event;
  logic        play;
  logic [3:0]  play_idx;
  logic [3:0]  step_q, step_d;
  logic        beat_q, beat_d;
  logic        bar_q, bar_d;
  logic [7:0]  gate_q, gate_d;
  // Sized to the full address range so the 4-bit step index never needs
  // bounds handling; entries at or above STEPS stay zero forever.
  logic [15:0] hit_q;

  assign tick_event = tick_in & ~tick_q;
  assign play       = enable & tick_event & ((state_q == S_ARMED) | (state_q == S_RUN));
  // The arming tick always starts the bar at step 0.
  assign play_idx   = ((state_q == S_ARMED) || (step_q == LAST_STEP)) ? 4'd0 : step_q + 4'd1;

  // Pattern storage: only indices below STEPS are ever written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q <= '0;
    end else if (pat_we) begin
      for (int i = 0; i < STEPS; i++) begin
        if (pat_addr == 4'(i)) hit_q[i] <= pat_data[0];
      end
    end
  end

`ifdef RHYTHM_SEQ_ACCENT_EN
  logic [15:0] acc_q;
  logic        accent_q, accent_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (pat_we) begin
      for (int i = 0; i < STEPS; i++) begin
        if (pat_addr == 4'(i)) acc_q[i] <= pat_data[1];
      end
    end
  end

  assign accent = accent_q;
`else
  logic unused_pat_accent;
  assign unused_pat_accent = pat_data[1];
  assign accent            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_ARMED;
      S_ARMED: begin
        if (!enable)         state_d = S_IDLE;
        else if (tick_event) state_d = S_RUN;
      end
      S_RUN:   if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    step_d   = step_q;
    beat_d   = beat_q;
    bar_d    = 1'b0;
    gate_d   = gate_q;
`ifdef RHYTHM_SEQ_ACCENT_EN
    accent_d = accent_q;
`endif
    if (state_d == S_IDLE) begin
      // Leaving the run rewinds and silences everything at once.
      step_d   = 4'd0;
      beat_d   = 1'b0;
      gate_d   = 8'd0;
`ifdef RHYTHM_SEQ_ACCENT_EN
      accent_d = 1'b0;
`endif
    end else if (play) begin
      // Pattern is read before any same-cycle write lands, so a write to the
      // step being played only affects its next play.
      step_d   = play_idx;
      bar_d    = (play_idx == 4'd0);
      beat_d   = hit_q[play_idx];
      gate_d   = hit_q[play_idx] ? GATE_RELOAD : 8'd0;
`ifdef RHYTHM_SEQ_ACCENT_EN
      accent_d = hit_q[play_idx] & acc_q[play_idx];
`endif
    end else if (beat_q) begin
      if (gate_q == 8'd0) begin
        beat_d   = 1'b0;
`ifdef RHYTHM_SEQ_ACCENT_EN
        accent_d = 1'b0;
`endif
      end else begin
        gate_d = gate_q - 8'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q   <= 1'b0;
      step_q   <= 4'd0;
      beat_q   <= 1'b0;
      bar_q    <= 1'b0;
      gate_q   <= 8'd0;
`ifdef RHYTHM_SEQ_ACCENT_EN
      accent_q <= 1'b0;
`endif
    end else begin
      tick_q   <= tick_in;
      step_q   <= step_d;
      beat_q   <= beat_d;
      bar_q    <= bar_d;
      gate_q   <= gate_d;
`ifdef RHYTHM_SEQ_ACCENT_EN
      accent_q <= accent_d;
`endif
    end
  end

  assign step      = step_q;
  assign beat      = beat_q;
  assign bar_start = bar_q;

endmodule

// File: tb/tb_rhythm_seq.sv
// Self-checking bench for rhythm_seq. A reference model tracks, per play,
// which step was played, its code and how many cycles ago it happened;
// beat/accent/bar_start are derived from that age arithmetically.
module tb_rhythm_seq;

  localparam int STEPS = 8;
  localparam int GATE  = 4;
`ifdef RHYTHM_SEQ_ACCENT_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       enable = 1'b0;
  logic       pat_we = 1'b0;
  logic [3:0] pat_addr = 4'd0;
  logic [1:0] pat_data = 2'd0;
  logic [3:0] step;
  logic       beat;
  logic       accent;
  logic       bar_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rhythm_seq #(.STEPS(STEPS), .GATE_LEN(GATE)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .enable    (enable),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .step      (step),
    .beat      (beat),
    .accent    (accent),
    .bar_start (bar_start)
  );

  // ---------------- reference model ----------------
  // m_mode: 0 stopped, 1 waiting for first tick, 2 running
  int         m_mode = 0;
  bit         m_prev = 1'b0;
  logic [1:0] m_pat [16];
  int         m_step = 0;
  bit         m_hit = 1'b0;
  bit         m_acc = 1'b0;
  int         m_age = 1000;   // cycles since the last play (1000 = none)

  always @(posedge clk) begin : ref_model
    int mode, st, age;
    bit hit, acc, ev;
    mode = m_mode; st = m_step; age = m_age; hit = m_hit; acc = m_acc;
    if (!reset) begin
      mode = 0; st = 0; age = 1000; hit = 1'b0; acc = 1'b0;
      m_prev <= 1'b0;
      for (int i = 0; i < 16; i++) m_pat[i] <= 2'b00;
    end else begin
      ev = tick_in && !m_prev;
      m_prev <= tick_in;
      if (mode != 0 && !enable) begin
        mode = 0; st = 0; age = 1000; hit = 1'b0; acc = 1'b0;
      end else if (mode == 0) begin
        if (enable) mode = 1;
      end else if (ev) begin
        st   = (mode == 1) ? 0 : (st + 1) % STEPS;
        mode = 2;
        hit  = m_pat[st][0];
        acc  = ACC && m_pat[st][1];
        age  = 0;
      end else if (age < 1000) begin
        age = age + 1;
      end
      if (pat_we && int'(pat_addr) < STEPS) m_pat[pat_addr] <= pat_data;
    end
    m_mode <= mode; m_step <= st; m_age <= age; m_hit <= hit; m_acc <= acc;
  end

  function automatic logic [6:0] expv();
    logic b;
    b = m_hit && (m_age < GATE);
    return {4'(m_step), b, b && m_acc, (m_age == 0) && (m_step == 0)};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic write_pat(input int a, input logic [1:0] d);
    pat_we = 1'b1; pat_addr = 4'(a); pat_data = d;
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  task automatic fill_pat(input logic [1:0] d);
    for (int i = 0; i < STEPS; i++) write_pat(i, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      enable = 1'b1; tick_in = c[0]; pat_we = 1'b1;
      pat_addr = 4'(c); pat_data = 2'b11;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== 7'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, 7'd0);
      end
    end
    reset = 1'b1; enable = 1'b0; tick_in = 1'b0; pat_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, beat, accent, bar_start} !== expv()) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b", {step, beat, accent, bar_start}, expv());
    end
    $display("test_reset done");
  endtask

  task automatic test_bar();
    logic [1:0] tbl [8];
    int bars;
    tbl = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < STEPS; i++) write_pat(i, tbl[i]);
    write_pat(9, 2'b11);   // out of range, must be ignored
    bars = 0;
    enable = 1'b1;
    for (int c = 0; c <= 2 * STEPS * 20 + 5; c++) begin
      tick_in = (c % 20) < 10;
      @(negedge clk);
      if (bar_start === 1'b1) bars++;
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL bar_pattern cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
    end
    checks++;
    if (bars !== 2) begin
      errors++;
      $display("FAIL bar_count got=%0d want=2", bars);
    end
    $display("test_bar done bars=%0d", bars);
  endtask

  task automatic test_continuous();
    tick_in = 1'b0;
    fill_pat(2'b01);
    for (int c = 0; c < 60; c++) begin
      tick_in = (c % 3) < 2;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL continuous cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (c >= 8) begin
        checks++;
        if (beat !== 1'b1) begin
          errors++;
          $display("FAIL continuous_gate cyc=%0d got=%b want=1", c, beat);
        end
      end
    end
    $display("test_continuous done");
  endtask

  task automatic test_accent();
    tick_in = 1'b0;
    fill_pat(2'b11);
    for (int c = 0; c < 60; c++) begin
      tick_in = (c % 5) < 2;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL accent_model cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (m_age == 0) begin
        checks++;
        if ({beat, accent} !== {1'b1, ACC}) begin
          errors++;
          $display("FAIL accent_play cyc=%0d got=%b want=%b", c, {beat, accent}, {1'b1, ACC});
        end
      end
    end
    $display("test_accent done");
  endtask

  task automatic test_enable_drop();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick_in = (c % 6) < 3;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL enable_run cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (m_step == 2 && m_age == 1 && m_hit) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_reach_step2 got=timeout want=step2");
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, beat, accent, bar_start} !== 7'd0) begin
      errors++;
      $display("FAIL enable_drop got=%b want=%b", {step, beat, accent, bar_start}, 7'd0);
    end
    enable = 1'b1; tick_in = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick_in = (c % 6) >= 3;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL enable_resume cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (!found && m_age == 0) begin
        found = 1'b1;
        checks++;
        if ({step, bar_start} !== {4'd0, 1'b1}) begin
          errors++;
          $display("FAIL enable_first_play got=%b want=%b", {step, bar_start}, {4'd0, 1'b1});
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_resume_play got=timeout want=play");
    end
    $display("test_enable_drop done");
  endtask

  task automatic test_write_collision();
    bit done, coll, later;
    tick_in = 1'b0;
    fill_pat(2'b01);
    done = 1'b0; later = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick_in = (c % 4) < 2;
      coll = 1'b0;
      if (!done && c > 0 && (c % 4) == 0 && m_mode == 2 && m_step == 0) begin
        pat_we = 1'b1; pat_addr = 4'd1; pat_data = 2'b00;
        done = 1'b1; coll = 1'b1;
      end else begin
        pat_we = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL collision_model cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (coll) begin
        checks++;
        if ({step, beat} !== {4'd1, 1'b1}) begin
          errors++;
          $display("FAIL collision_old_data got=%b want=%b", {step, beat}, {4'd1, 1'b1});
        end
      end else if (done && m_step == 1 && m_age == 0) begin
        later = 1'b1;
        checks++;
        if ({step, beat} !== {4'd1, 1'b0}) begin
          errors++;
          $display("FAIL collision_new_data got=%b want=%b", {step, beat}, {4'd1, 1'b0});
        end
      end
    end
    pat_we = 1'b0;
    checks++;
    if (!(done && later)) begin
      errors++;
      $display("FAIL collision_reached got=%0d%0d want=11", done, later);
    end
    $display("test_write_collision done");
  endtask

  task automatic test_reset_midrun();
    bit found;
    tick_in = 1'b0;
    fill_pat(2'b01);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick_in = (c % 4) < 2;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL midrun_run cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      if (m_step == 5 && m_age == 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrun_reach_step5 got=timeout want=step5");
    end
    reset = 1'b0; tick_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, beat, accent, bar_start} !== 7'd0) begin
      errors++;
      $display("FAIL midrun_reset got=%b want=%b", {step, beat, accent, bar_start}, 7'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 16 * 4 + 8; c++) begin
      tick_in = (c % 4) >= 2;
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL midrun_after cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
      checks++;
      if (beat !== 1'b0) begin
        errors++;
        $display("FAIL midrun_cleared cyc=%0d got=%b want=0", c, beat);
      end
    end
    $display("test_reset_midrun done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) != 0);
      enable   = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      pat_we   = ($urandom_range(0, 4) == 0);
      pat_addr = 4'($urandom_range(0, 15));
      pat_data = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if ({step, beat, accent, bar_start} !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, {step, beat, accent, bar_start}, expv());
      end
    end
    reset = 1'b1; pat_we = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_bar();
    test_continuous();
    test_accent();
    test_enable_drop();
    test_write_collision();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
